// File: rtl/dna_port_responder.sv
// Responder-side emulation of a device-DNA serial port with a bus-programmable,
// lockable 57-bit ID. All logic runs on clk_48; the serial pins are synchronised.
module dna_port_responder #(
  parameter int                  ID_WIDTH    = 57,
  parameter logic [ID_WIDTH-1:0] DEFAULT_ID  = '0,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic        clk_48,
  input  logic        rst_n,
  input  logic        id_clk,
  input  logic        id_read,
  input  logic        id_shift,
  input  logic        id_din,
  output logic        id_dout,
  input  logic        avalid,
  input  logic        awrite,
  input  logic [2:2]  aaddr,
  input  logic [31:0] awdata,
  output logic        aready,
  output logic        bvalid,
  output logic [31:0] bdata,
  output logic        locked
);

  // Bus handshake: a request is held on avalid until aready; aready is bvalid,
  // so each accepted request yields a one-cycle bvalid pulse and a held avalid
  // produces a fresh pulse every other cycle.

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] read_sync_q, read_sync_d;
  logic [SYNC_STAGES-1:0] shift_sync_q, shift_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [ID_WIDTH-1:0]    sreg_q, sreg_d;
  logic [ID_WIDTH-1:0]    id_reg_q, id_reg_d;
  logic                   dout_q, dout_d;
  logic                   bvalid_q, bvalid_d;
  logic                   locked_q, locked_d;
  logic                   rise;
  logic                   accept;
  logic                   unused_awdata;

  assign unused_awdata = ^awdata[30:25];

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], id_clk};
    read_sync_d  = {read_sync_q[SYNC_STAGES-2:0], id_read};
    shift_sync_d = {shift_sync_q[SYNC_STAGES-2:0], id_shift};
    din_sync_d   = {din_sync_q[SYNC_STAGES-2:0], id_din};
    clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
    rise         = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

    // Controls come from the same stage as id_clk so they stay aligned with it.
    sreg_d = sreg_q;
    if (rise) begin
      if (read_sync_q[SYNC_STAGES-1]) begin
        sreg_d = id_reg_q;
      end else if (shift_sync_q[SYNC_STAGES-1]) begin
        sreg_d = {sreg_q[ID_WIDTH-2:0], din_sync_q[SYNC_STAGES-1]};
      end
    end
    dout_d = sreg_q[ID_WIDTH-1];

    bvalid_d = avalid & ~bvalid_q;
    accept   = avalid & bvalid_q;

    id_reg_d = id_reg_q;
    locked_d = locked_q;
    if (accept && awrite && !locked_q) begin
      if (aaddr == 1'b0) begin
        id_reg_d[31:0] = awdata;
      end else begin
        id_reg_d[ID_WIDTH-1:32] = awdata[ID_WIDTH-33:0];
        if (awdata[31]) begin
          locked_d = 1'b1;
        end
      end
    end

    if (aaddr == 1'b0) begin
      bdata = id_reg_q[31:0];
    end else begin
      bdata = {locked_q, 6'b0, id_reg_q[ID_WIDTH-1:32]};
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '0;
      read_sync_q  <= '0;
      shift_sync_q <= '0;
      din_sync_q   <= '0;
      clk_prev_q   <= 1'b0;
      sreg_q       <= '0;
      id_reg_q     <= DEFAULT_ID;
      dout_q       <= 1'b0;
      bvalid_q     <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      read_sync_q  <= read_sync_d;
      shift_sync_q <= shift_sync_d;
      din_sync_q   <= din_sync_d;
      clk_prev_q   <= clk_prev_d;
      sreg_q       <= sreg_d;
      id_reg_q     <= id_reg_d;
      dout_q       <= dout_d;
      bvalid_q     <= bvalid_d;
      locked_q     <= locked_d;
    end
  end

  assign id_dout = dout_q;
  assign bvalid  = bvalid_q;
  assign aready  = bvalid_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_dna_port_responder.sv
// Scoreboarded bench for dna_port_responder: bus and serial expectations come
// from an abstract ID/lock/shift-register model and are checked by monitors.
module tb_dna_port_responder;

  localparam logic [56:0] DEF_ID = 57'h1BC_DEF0_1234_5678;
  localparam int          HALF   = 16;

  logic        clk_48 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        id_clk = 1'b0, id_read = 1'b0, id_shift = 1'b0, id_din = 1'b0;
  logic        id_dout;
  logic        avalid = 1'b0, awrite = 1'b0;
  logic [2:2]  aaddr = 1'b0;
  logic [31:0] awdata = '0;
  logic        aready, bvalid, locked;
  logic [31:0] bdata;

  int checks = 0;
  int errors = 0;
  bit ser_mon_en = 1'b1;

  // {is_read, locked, bdata} per bus request; one expected dout bit per shift
  logic [33:0] exp_q[$];
  logic [0:0]  ser_q[$];

  // behavioural model
  logic [56:0] m_id     = DEF_ID;
  logic        m_locked = 1'b0;
  logic [56:0] m_sreg   = '0;

  dna_port_responder #(.ID_WIDTH(57), .DEFAULT_ID(DEF_ID), .SYNC_STAGES(2)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .id_clk(id_clk), .id_read(id_read),
    .id_shift(id_shift), .id_din(id_din), .id_dout(id_dout), .avalid(avalid),
    .awrite(awrite), .aaddr(aaddr), .awdata(awdata), .aready(aready),
    .bvalid(bvalid), .bdata(bdata), .locked(locked)
  );

  // clock / reset
  always #5 clk_48 = ~clk_48;

  initial begin
    #3ms;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic a);
    return a ? {m_locked, 6'b0, m_id[56:32]} : m_id[31:0];
  endfunction

  task automatic do_reset();
    @(negedge clk_48);
    rst_n = 1'b0; id_clk = 1'b0; id_read = 1'b0; id_shift = 1'b0;
    avalid = 1'b0;
    repeat (3) @(negedge clk_48);
    rst_n = 1'b1;
    m_id = DEF_ID; m_locked = 1'b0; m_sreg = '0;
  endtask

  // driver tasks
  task automatic bus_req(input logic wr, input logic a, input logic [31:0] d);
    int t;
    exp_q.push_back({~wr, m_locked, model_read(a)});
    @(negedge clk_48);
    avalid = 1'b1; awrite = wr; aaddr = a; awdata = d;
    t = 0;
    do begin
      @(negedge clk_48);
      t++;
    end while (!bvalid && t < 20);
    checks++;
    if (!bvalid) begin
      errors++;
      $display("FAIL bus_timeout: bvalid=%0b expected 1", bvalid);
      void'(exp_q.pop_back());
    end
    @(negedge clk_48);
    avalid = 1'b0; awrite = 1'b0;
    if (wr && !m_locked) begin
      if (a == 1'b0) m_id[31:0] = d;
      else begin
        m_id[56:32] = d[24:0];
        if (d[31]) m_locked = 1'b1;
      end
    end
  endtask

  task automatic ser_pulse(input logic rd, input logic sh, input logic din);
    @(negedge clk_48);
    if (sh && !rd) ser_q.push_back(m_sreg[56]);
    id_read = rd; id_shift = sh; id_din = din; id_clk = 1'b1;
    if (rd) m_sreg = m_id;
    else if (sh) m_sreg = {m_sreg[55:0], din};
    repeat (HALF) @(negedge clk_48);
    id_clk = 1'b0;
    repeat (HALF) @(negedge clk_48);
    id_read = 1'b0; id_shift = 1'b0;
  endtask

  // din_mode: 0 -> zeros, 1 -> ones, 2 -> random
  task automatic ser_shifts(input int n, input int din_mode);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (din_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(din_mode);
      ser_pulse(1'b0, 1'b1, b);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk_48) begin
    if (rst_n && bvalid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: bvalid=1 expected no response");
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("bus_locked", 64'(locked), 64'(e[32]));
        if (e[33]) chk("bus_rdata", 64'(bdata), 64'(e[31:0]));
      end
    end
  end

  always @(posedge id_clk) begin
    if (ser_mon_en && id_shift && !id_read) begin
      if (ser_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ser_unexpected: dout=%0b with no expectation", id_dout);
      end else begin
        chk("ser_dout", 64'(id_dout), 64'(ser_q.pop_front()));
      end
    end
  end

  // stimulus
  initial begin
    repeat (3) @(negedge clk_48);
    rst_n = 1'b1;
    @(negedge clk_48);
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_aready", 64'(aready), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_dout", 64'(id_dout), 64'(0));
    chk("rst_bdata0", 64'(bdata), 64'(DEF_ID[31:0]));
    aaddr = 1'b1;
    @(negedge clk_48);
    chk("rst_bdata1", 64'(bdata), 64'({7'b0, DEF_ID[56:32]}));
    aaddr = 1'b0;

    // default ID read out MSB first
    ser_pulse(1'b1, 1'b0, 1'b0);
    ser_shifts(57, 0);

    // program, read back, serial read
    bus_req(1'b1, 1'b0, 32'hDEADBEEF);
    bus_req(1'b1, 1'b1, 32'h0123_4567);
    bus_req(1'b0, 1'b0, 32'h0);
    bus_req(1'b0, 1'b1, 32'h0);
    chk("prog_id", 64'(m_id), 64'(57'h0_0123_4567_DEADBEEF));
    ser_pulse(1'b1, 1'b0, 1'b0);
    ser_shifts(57, 0);

    // read and shift together: load wins; then shift ones all the way through
    ser_pulse(1'b1, 1'b1, 1'b1);
    ser_shifts(57 + 57 + 3, 1);

    // held avalid: pulses every other cycle, one commit per pulse
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, m_locked, 32'h0});
    @(negedge clk_48);
    avalid = 1'b1; awrite = 1'b1; aaddr = 1'b0; awdata = 32'hA5A5_0F0F;
    for (int k = 0; k < 6; k++) begin
      chk("hold_bvalid", 64'(bvalid), 64'(k % 2));
      @(negedge clk_48);
    end
    avalid = 1'b0; awrite = 1'b0;
    m_id[31:0] = 32'hA5A5_0F0F;
    bus_req(1'b0, 1'b0, 32'h0);

    // randomised program/readback/serial rounds
    for (int r = 0; r < 4; r++) begin
      bus_req(1'b1, 1'b0, $urandom);
      bus_req(1'b1, 1'b1, $urandom & 32'h7FFF_FFFF);
      bus_req(1'b0, 1'($urandom_range(0, 1)), 32'h0);
      bus_req(1'b0, 1'b1, 32'h0);
      ser_pulse(1'b1, 1'b0, 1'b0);
      ser_shifts(57 + $urandom_range(0, 8), 2);
    end

    // lock, then a locked write is acknowledged but ignored
    bus_req(1'b1, 1'b1, 32'h8155_AA55);
    @(negedge clk_48);
    chk("lock_out", 64'(locked), 64'(1));
    bus_req(1'b0, 1'b1, 32'h0);
    bus_req(1'b1, 1'b0, 32'h0);
    bus_req(1'b1, 1'b1, 32'h0);
    bus_req(1'b0, 1'b0, 32'h0);
    bus_req(1'b0, 1'b1, 32'h0);
    ser_pulse(1'b1, 1'b0, 1'b0);
    ser_shifts(57, 2);
    do_reset();
    @(negedge clk_48);
    chk("unlock_rst", 64'(locked), 64'(0));
    bus_req(1'b0, 1'b0, 32'h0);
    bus_req(1'b0, 1'b1, 32'h0);

    // reset in the middle of a readout clears the shifter
    ser_pulse(1'b1, 1'b0, 1'b0);
    ser_shifts(20, 0);
    do_reset();
    ser_shifts(4, 0);
    ser_pulse(1'b1, 1'b0, 1'b0);
    // sub-cycle glitch on id_clk never reaches the synchroniser
    ser_mon_en = 1'b0;
    @(negedge clk_48);
    #1 id_shift = 1'b1; id_din = 1'b1; id_clk = 1'b1;
    #2 id_clk = 1'b0; id_shift = 1'b0;
    repeat (2 * HALF) @(negedge clk_48);
    ser_mon_en = 1'b1;
    ser_shifts(57, 0);

    repeat (10) @(negedge clk_48);
    chk("bus_q_empty", 64'(exp_q.size()), 64'(0));
    chk("ser_q_empty", 64'(ser_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
